// File: rtl/calc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : calc_pkg
// Description : Shared state encodings and constants for the calculator
//               operator-entry controller.
// Revision    : 1.0 - initial release
// ============================================================================
package calc_pkg;

    // FSM state encodings, also shown on the LED status display
    localparam logic [2:0] ST_ENTER_A  = 3'd0;
    localparam logic [2:0] ST_ENTER_B  = 3'd1;
    localparam logic [2:0] ST_ENTER_OP = 3'd2;
    localparam logic [2:0] ST_EXEC     = 3'd3;
    localparam logic [2:0] ST_WAIT     = 3'd4;
    localparam logic [2:0] ST_SHOW     = 3'd5;
    localparam logic [2:0] ST_ERROR    = 3'd6;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    // Wide enough for any display up to 64 bits; users slice the low bits
    localparam logic [63:0] ERR_DISPLAY = '1;

endpackage
`default_nettype wire

// File: rtl/calc_timeout_ctr.sv
`default_nettype none
// ============================================================================
// Module      : calc_timeout_ctr
// Description : Loadable down-counter that flags when the ALU wait budget
//               runs out.
// Revision    : 1.0 - initial release
// ============================================================================
module calc_timeout_ctr #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic en,
    output logic expired
);

    localparam int          CW     = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] c_one  = CW'(1);
    localparam logic [CW-1:0] c_init = CW'(TIMEOUT);

    logic [CW-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= c_init;
        end else if (en && (r_count != '0)) begin
            r_count <= r_count - c_one;
        end
    end

    // High during the cycle whose closing edge takes the count to zero
    assign expired = en && (r_count <= c_one);

endmodule
`default_nettype wire

// File: rtl/calc_input_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : calc_input_sequencer
// Description : Operator-entry FSM: captures A, B and opcode from switches,
//               launches the ALU, waits for done and holds the result.
//               Optional macro CALC_CHAIN_EN chains the result into A.
// Revision    : 1.0 - initial release
// ============================================================================
module calc_input_sequencer
    import calc_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [WIDTH-1:0]   sw,
    input  logic               btn_enter,
    input  logic               btn_clear,
    input  logic               alu_done,
    input  logic [2*WIDTH-1:0] alu_result,
    output logic [WIDTH-1:0]   alu_a,
    output logic [WIDTH-1:0]   alu_b,
    output logic [1:0]         alu_op,
    output logic               alu_start,
    output logic [2*WIDTH-1:0] disp_value,
    output logic [2:0]         state_code,
    output logic               err
);

    logic [2:0]         r_state;
    logic [2:0]         w_next_state;
    logic [WIDTH-1:0]   r_alu_a;
    logic [WIDTH-1:0]   r_alu_b;
    logic [1:0]         r_alu_op;
    logic               r_alu_start;
    logic [2*WIDTH-1:0] r_result;
    logic               r_err;
    logic               w_expired;

    calc_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .load    (r_state == ST_EXEC),
        .en      (r_state == ST_WAIT),
        .expired (w_expired)
    );

    always_comb begin
        w_next_state = r_state;
        if (btn_clear) begin
            w_next_state = ST_ENTER_A;
        end else begin
            case (r_state)
                ST_ENTER_A:  if (btn_enter) w_next_state = ST_ENTER_B;
                ST_ENTER_B:  if (btn_enter) w_next_state = ST_ENTER_OP;
                ST_ENTER_OP: if (btn_enter) w_next_state = ST_EXEC;
                ST_EXEC:     w_next_state = ST_WAIT;
                ST_WAIT: begin
                    // A done on the final counted cycle beats the timeout
                    if (alu_done)       w_next_state = ST_SHOW;
                    else if (w_expired) w_next_state = ST_ERROR;
                end
                ST_SHOW: begin
                    if (btn_enter) begin
`ifdef CALC_CHAIN_EN
                        w_next_state = ST_ENTER_B;
`else
                        w_next_state = ST_ENTER_A;
`endif
                    end
                end
                ST_ERROR:    w_next_state = ST_ERROR;
                default:     w_next_state = ST_ENTER_A;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset || btn_clear) begin
            r_state     <= ST_ENTER_A;
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_alu_op    <= OP_ADD;
            r_alu_start <= 1'b0;
            r_result    <= '0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_alu_start <= (w_next_state == ST_EXEC);
            case (r_state)
                ST_ENTER_A:  if (btn_enter) r_alu_a  <= sw;
                ST_ENTER_B:  if (btn_enter) r_alu_b  <= sw;
                ST_ENTER_OP: if (btn_enter) r_alu_op <= sw[1:0];
                ST_WAIT: begin
                    if (alu_done)       r_result <= alu_result;
                    else if (w_expired) r_err    <= 1'b1;
                end
`ifdef CALC_CHAIN_EN
                ST_SHOW:     if (btn_enter) r_alu_a <= r_result[WIDTH-1:0];
`endif
                default: ;
            endcase
        end
    end

    always_comb begin
        case (r_state)
            ST_ENTER_A, ST_ENTER_B, ST_ENTER_OP:
                disp_value = {{WIDTH{1'b0}}, sw};
            ST_ERROR:
                disp_value = ERR_DISPLAY[2*WIDTH-1:0];
            default:
                disp_value = r_result;
        endcase
    end

    assign alu_a      = r_alu_a;
    assign alu_b      = r_alu_b;
    assign alu_op     = r_alu_op;
    assign alu_start  = r_alu_start;
    assign state_code = r_state;
    assign err        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_calc_input_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_calc_input_sequencer
// Description : Self-checking bench for calc_input_sequencer (TIMEOUT = 4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_calc_input_sequencer;

    localparam int WIDTH   = 8;
    localparam int TIMEOUT = 4;

    logic               clk = 1'b0;
    logic               reset;
    logic [WIDTH-1:0]   sw;
    logic               btn_enter;
    logic               btn_clear;
    logic               alu_done;
    logic [2*WIDTH-1:0] alu_result;
    logic [WIDTH-1:0]   alu_a;
    logic [WIDTH-1:0]   alu_b;
    logic [1:0]         alu_op;
    logic               alu_start;
    logic [2*WIDTH-1:0] disp_value;
    logic [2:0]         state_code;
    logic               err;

    int tests_run    = 0;
    int tests_failed = 0;

    calc_input_sequencer #(
        .WIDTH   (WIDTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .sw         (sw),
        .btn_enter  (btn_enter),
        .btn_clear  (btn_clear),
        .alu_done   (alu_done),
        .alu_result (alu_result),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_start  (alu_start),
        .disp_value (disp_value),
        .state_code (state_code),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: state numbers, captured values and cycles spent waiting
    int               m_state  = 0;
    logic [WIDTH-1:0] m_a      = '0;
    logic [WIDTH-1:0] m_b      = '0;
    logic [1:0]       m_op     = '0;
    logic [15:0]      m_result = '0;
    logic             m_err    = 1'b0;
    int               m_waited = 0;
    bit               m_valid  = 1'b0;

    always @(posedge clk) begin
        m_valid <= 1'b1;
        if (reset || btn_clear) begin
            m_state <= 0; m_a <= '0; m_b <= '0; m_op <= '0;
            m_result <= '0; m_err <= 1'b0; m_waited <= 0;
        end else begin
            case (m_state)
                0: if (btn_enter) begin m_a  <= sw;      m_state <= 1; end
                1: if (btn_enter) begin m_b  <= sw;      m_state <= 2; end
                2: if (btn_enter) begin m_op <= sw[1:0]; m_state <= 3; end
                3: begin m_waited <= 0; m_state <= 4; end
                4: begin
                    if (alu_done) begin
                        m_result <= alu_result;
                        m_state  <= 5;
                    end else if (m_waited + 1 == TIMEOUT) begin
                        m_err   <= 1'b1;
                        m_state <= 6;
                    end else begin
                        m_waited <= m_waited + 1;
                    end
                end
                5: if (btn_enter) begin
`ifdef CALC_CHAIN_EN
                    m_a     <= m_result[WIDTH-1:0];
                    m_state <= 1;
`else
                    m_state <= 0;
`endif
                end
                default: ;
            endcase
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("cyc_state", 32'(state_code), 32'(m_state));
            check("cyc_alu_a", 32'(alu_a), 32'(m_a));
            check("cyc_alu_b", 32'(alu_b), 32'(m_b));
            check("cyc_alu_op", 32'(alu_op), 32'(m_op));
            check("cyc_start", 32'(alu_start), 32'(m_state == 3));
            check("cyc_err", 32'(err), 32'(m_err));
            if (m_state <= 2)  check("cyc_disp_entry", 32'(disp_value), 32'(sw));
            if (m_state == 5)  check("cyc_disp_show", 32'(disp_value), 32'(m_result));
            if (m_state == 6)  check("cyc_disp_err", 32'(disp_value), 32'hFFFF);
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press_enter(input logic [7:0] v);
        sw = v; btn_enter = 1'b1;
        step(1);
        btn_enter = 1'b0;
    endtask

    task automatic press_clear();
        btn_clear = 1'b1;
        step(1);
        btn_clear = 1'b0;
    endtask

    task automatic pulse_done(input logic [15:0] r);
        alu_done = 1'b1; alu_result = r;
        step(1);
        alu_done = 1'b0; alu_result = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; sw = 8'h5A; btn_enter = 1'b0; btn_clear = 1'b0;
        alu_done = 1'b0; alu_result = '0;
        step(3);
        check("rst_state", 32'(state_code), 32'd0);
        check("rst_alu_a", 32'(alu_a), 32'd0);
        check("rst_start", 32'(alu_start), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_disp", 32'(disp_value), 32'h005A);
        reset = 1'b0;
        step(1);

        // Basic add 0x12 + 0x34, done three cycles after the start pulse
        press_enter(8'h12);
        press_enter(8'h34);
        press_enter(8'h00);
        check("add_start", 32'(alu_start), 32'd1);
        check("add_state_exec", 32'(state_code), 32'd3);
        step(3);
        check("add_start_gone", 32'(alu_start), 32'd0);
        pulse_done(16'h0046);
        check("add_state_show", 32'(state_code), 32'd5);
        check("add_disp", 32'(disp_value), 32'h0046);
        check("add_a", 32'(alu_a), 32'h12);
        check("add_b", 32'(alu_b), 32'h34);
        check("add_op", 32'(alu_op), 32'd0);

        // Stray done in SHOW and in ENTER_A
        pulse_done(16'hBEEF);
        check("stray_show_state", 32'(state_code), 32'd5);
        check("stray_show_disp", 32'(disp_value), 32'h0046);
        press_clear();
        sw = 8'h07;
        pulse_done(16'hBEEF);
        check("stray_a_state", 32'(state_code), 32'd0);
        check("stray_a_disp", 32'(disp_value), 32'h0007);

        // Clear beats enter in ENTER_B
        press_enter(8'h55);
        check("clr_pre_state", 32'(state_code), 32'd1);
        btn_clear = 1'b1;
        press_enter(8'h66);
        btn_clear = 1'b0;
        check("clr_state", 32'(state_code), 32'd0);
        check("clr_alu_a", 32'(alu_a), 32'd0);
        check("clr_alu_b", 32'(alu_b), 32'd0);

        // Timeout: ERROR exactly TIMEOUT+1 cycles after EXEC
        press_enter(8'h09);
        press_enter(8'h03);
        press_enter(8'h03);
        check("to_exec", 32'(state_code), 32'd3);
        step(4);
        check("to_still_wait", 32'(state_code), 32'd4);
        step(1);
        check("to_error", 32'(state_code), 32'd6);
        check("to_err", 32'(err), 32'd1);
        check("to_disp", 32'(disp_value), 32'hFFFF);
        press_enter(8'h01);
        check("to_enter_ignored", 32'(state_code), 32'd6);
        press_clear();
        check("to_clear_state", 32'(state_code), 32'd0);
        check("to_clear_err", 32'(err), 32'd0);

        // Done on the last counted cycle wins over the timeout
        press_enter(8'h02);
        press_enter(8'h03);
        press_enter(8'h01);
        step(4);
        pulse_done(16'h00FF);
        check("edge_done_state", 32'(state_code), 32'd5);
        check("edge_done_err", 32'(err), 32'd0);
        check("edge_done_disp", 32'(disp_value), 32'h00FF);
        press_clear();

        // Chaining after a mul result of 0x0123
        press_enter(8'h11);
        press_enter(8'h11);
        press_enter(8'h02);
        check("mul_op", 32'(alu_op), 32'd2);
        step(1);
        pulse_done(16'h0123);
        check("mul_disp", 32'(disp_value), 32'h0123);
        press_enter(8'hAA);
`ifdef CALC_CHAIN_EN
        check("chain_state", 32'(state_code), 32'd1);
        check("chain_alu_a", 32'(alu_a), 32'h23);
`else
        check("chain_state", 32'(state_code), 32'd0);
        check("chain_alu_a", 32'(alu_a), 32'h11);
`endif
        press_clear();

        // Reset mid-WAIT, then a late done
        press_enter(8'h21);
        press_enter(8'h43);
        press_enter(8'h01);
        step(1);
        check("rw_wait", 32'(state_code), 32'd4);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        step(1);
        pulse_done(16'h1234);
        check("rw_state", 32'(state_code), 32'd0);
        check("rw_alu_a", 32'(alu_a), 32'd0);
        check("rw_alu_b", 32'(alu_b), 32'd0);
        check("rw_alu_op", 32'(alu_op), 32'd0);
        check("rw_start", 32'(alu_start), 32'd0);
        check("rw_err", 32'(err), 32'd0);
        check("rw_disp", 32'(disp_value), 32'(sw));

        step(2);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/calc_input_sequencer.md
# calc_input_sequencer

Operator-entry controller for the 8-bit calculator. It consumes the single-cycle button pulses produced by the debouncers, captures operand A, operand B and the opcode from the slide switches in sequence, and launches the shared ALU. It then waits for completion and holds the result for the display path. It is the only block that drives the ALU's operand, opcode and start inputs.

## Interface
- WIDTH, 8, operand width in bits
- TIMEOUT, 255, max cycles waited for `alu_done` before flagging an error (≥1)
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- sw  input  WIDTH  slide switches: operand value, or opcode in bits [1:0]
- btn_enter  input  1  debounced one-cycle pulse: accept current entry
- btn_clear  input  1  debounced one-cycle pulse: abort and return to operand-A entry
- alu_done  input  1  one-cycle pulse from ALU: result valid
- alu_result  input  2*WIDTH  ALU result, valid with `alu_done`
- alu_a  output  WIDTH  registered operand A
- alu_b  output  WIDTH  registered operand B
- alu_op  output  2  registered opcode: 00 add, 01 sub, 10 mul, 11 div
- alu_start  output  1  one-cycle launch pulse
- disp_value  output  2*WIDTH  value for the display: live `sw` while entering, latched result in SHOW
- state_code  output  3  current state encoding, used by the LED status display
- err  output  1  sticky ALU-timeout flag

## Operation
- States:
  - ENTER_A=0, ENTER_B=1, ENTER_OP=2, EXEC=3, WAIT=4, SHOW=5, ERROR=6
- Transitions:
  - ENTER_A --enter--> ENTER_B; `alu_a` ← `sw`.
  - ENTER_B --enter--> ENTER_OP; `alu_b` ← `sw`.
  - ENTER_OP --enter--> EXEC; `alu_op` ← `sw[1:0]`.
  - EXEC: unconditional, one cycle. `alu_start` = 1, and the timeout counter is loaded with TIMEOUT. Next state is WAIT.
  - WAIT --`alu_done`--> SHOW; the result register ← `alu_result`.
  - WAIT: the counter decrements each cycle. If it reaches 0 without `alu_done`, go to ERROR and set `err`.
  - SHOW --enter--> ENTER_A. With CALC_CHAIN_EN defined, see Configuration.
  - ERROR: `disp_value` = all ones. Only `btn_clear` leaves this state.
- `btn_clear` from any state:
  - Goes to ENTER_A and clears `alu_a`, `alu_b`, `alu_op`, the result register and `err`.
  - Has priority over `btn_enter` in the same cycle.
- Reset mid-operation:
  - Identical to clear.
  - An `alu_done` arriving after the abort is ignored.
- `alu_done` outside WAIT is ignored; a late done never updates the result.
- `btn_enter` in EXEC or WAIT is ignored. Pulses are not queued.
- `alu_a`, `alu_b` and `alu_op` stay stable from EXEC through SHOW.
- `disp_value` in the entry states is `sw`, zero-extended to 2*WIDTH.

## Timing
- Reset values:
  - state = ENTER_A; `alu_a`, `alu_b`, `alu_op` = 0.
  - `alu_start` = 0, `err` = 0, result register = 0.
  - `state_code` = 0. `disp_value` shows `sw` zero-extended.
- Entry latency:
  - An enter pulse sampled at edge n updates the register and state at edge n+1.
  - A `sw` change in the same cycle as enter is captured.
- Launch: `alu_start` is high for exactly the one cycle spent in EXEC, i.e. the cycle after the opcode enter.
- Completion: `alu_done` sampled at edge n gives SHOW and the latched result at n+1.
- Timeout:
  - ERROR is reached exactly TIMEOUT+1 cycles after EXEC when no done arrives.
  - A done arriving on the same edge the counter hits 0 wins, and the FSM goes to SHOW.
- All outputs are registered except `disp_value`, which is combinational from `sw` in the entry states.

## Configuration
- CALC_CHAIN_EN:
  - Defined: `btn_enter` in SHOW loads `alu_a` ← `result[WIDTH-1:0]` and goes to ENTER_B, so the next operation chains on the previous result. The upper result bits are dropped.
  - Undefined: enter in SHOW goes to ENTER_A and `alu_a` keeps its old value until it is re-entered.

## Structure
- Package `calc_pkg`:
  - state enum and its 3-bit encodings
  - opcode constants: OP_ADD, OP_SUB, OP_MUL, OP_DIV
  - ERR_DISPLAY constant (all ones)
- Sub-module `calc_timeout_ctr`:
  - load, decrement and zero-detect counter, $clog2(TIMEOUT+1) bits wide
  - inputs: `load`, `en`; output: `expired`
- Everything else, the FSM and the operand registers, lives in `calc_input_sequencer`.

## Test plan
- Basic add:
  - Stimulus: sw=0x12 enter, sw=0x34 enter, sw=0x00 enter; ALU model returns done 3 cycles after start with 0x0046.
  - Response: `alu_start` for one cycle after the third enter, `alu_a`=0x12, `alu_b`=0x34, `alu_op`=00; SHOW with `disp_value`=0x0046.
- Clear priority: clear and enter in the same cycle in ENTER_B → state ENTER_A, `alu_a`=0, no capture.
- Timeout:
  - Stimulus: TIMEOUT=4, no `alu_done`.
  - Response: ERROR exactly 5 cycles after EXEC, `err`=1, `disp_value`=0xFFFF. Enter is ignored; clear returns to ENTER_A with `err`=0.
- Stray done: `alu_done` pulse in ENTER_A and in SHOW → result and state unchanged.
- Reset mid-WAIT: reset asserted, then `alu_done` 2 cycles later → all outputs at reset values and the result stays 0.
- Chaining:
  - Stimulus: after a mul giving 0x0123, press enter in SHOW.
  - Response: with CALC_CHAIN_EN, ENTER_B and `alu_a`=0x23. Without it, ENTER_A and `alu_a` unchanged.
